// File: rtl/i2c_channel_streamer.sv
// I2C write-frame transmitter: snapshots NUM_CH words on start and sends
// addr + data bytes, checking each ACK. Ports: clk/rst_n, start,
// i2c_address, endian, ch_data in; scl, sda_drive_low out; sda_i in;
// busy/done/err status. Optional I2C_NACK_RETRY_EN: one automatic
// re-send after the first NACK of a frame.
module i2c_channel_streamer #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 16,
  parameter int DIV    = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [6:0]               i2c_address,
  input  logic                     endian,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     scl,
  output logic                     sda_drive_low,
  input  logic                     sda_i,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int BYTES = DATA_W / 8;
  localparam int TOTAL = 1 + NUM_CH * BYTES;
  localparam int FW    = TOTAL * 8;
  localparam int CW    = $clog2(DIV);
  localparam int BW    = $clog2(TOTAL);

  typedef enum logic [2:0] {
    IDLE, START, BIT, ACK,
    STOP_A, STOP_B, STOP_C, GAP
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            phase_q, phase_n;
  logic [2:0]      bit_q, bit_n;
  logic [BW-1:0]   byte_q, byte_n;
  logic [FW-1:0]   frame_q, frame_n;
  logic [FW-1:0]   cap;
  logic            err_n, done_n;
  logic            half_end;
  logic            cur_bit;
`ifdef I2C_NACK_RETRY_EN
  logic            retried_q, retried_n;
  logic            pend_q, pend_n;
`endif

  // byte i of the frame lives at frame[i*8 +: 8], sent MSB first
  always_comb begin
    cap = '0;
    cap[7:0] = {i2c_address, 1'b0};
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (endian)
          cap[(1+c*BYTES+b)*8 +: 8] =
            ch_data[c*DATA_W+(BYTES-1-b)*8 +: 8];
        else
          cap[(1+c*BYTES+b)*8 +: 8] =
            ch_data[c*DATA_W+b*8 +: 8];
      end
    end
  end

  assign half_end = (cnt_q == CW'(DIV-1));
  assign cur_bit  = frame_q[{byte_q, ~bit_q}];
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    phase_n = phase_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    frame_n = frame_q;
    err_n   = err;
    done_n  = 1'b0;
`ifdef I2C_NACK_RETRY_EN
    retried_n = retried_q;
    pend_n    = pend_q;
`endif
    if (state_q != IDLE)
      cnt_n = half_end ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = START;
          cnt_n   = '0;
          frame_n = cap;
          err_n   = 1'b0;
          byte_n  = '0;
          bit_n   = '0;
          phase_n = 1'b0;
`ifdef I2C_NACK_RETRY_EN
          retried_n = 1'b0;
          pend_n    = 1'b0;
`endif
        end
      end
      START: begin
        if (half_end) begin
          state_n = BIT;
          phase_n = 1'b0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      BIT: begin
        if (half_end) begin
          phase_n = ~phase_q;
          if (phase_q) begin
            bit_n = bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_n = ACK;
          end
        end
      end
      ACK: begin
        if (half_end) begin
          phase_n = ~phase_q;
          if (phase_q) begin
            if (sda_i) begin
              state_n = STOP_A;
`ifdef I2C_NACK_RETRY_EN
              if (!retried_q) begin
                retried_n = 1'b1;
                pend_n    = 1'b1;
              end else begin
                err_n = 1'b1;
              end
`else
              err_n = 1'b1;
`endif
            end else if (byte_q == BW'(TOTAL-1)) begin
              state_n = STOP_A;
            end else begin
              state_n = BIT;
              byte_n  = byte_q + 1'b1;
            end
          end
        end
      end
      STOP_A: if (half_end) state_n = STOP_B;
      STOP_B: if (half_end) state_n = STOP_C;
      STOP_C: begin
        if (half_end) begin
`ifdef I2C_NACK_RETRY_EN
          if (pend_q) begin
            pend_n  = 1'b0;
            state_n = GAP;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end
      end
      GAP: begin
        if (half_end) begin
          state_n = START;
          byte_n  = '0;
          bit_n   = '0;
          phase_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      retried_q <= 1'b0;
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      frame_q <= frame_n;
      err     <= err_n;
      done    <= done_n;
`ifdef I2C_NACK_RETRY_EN
      retried_q <= retried_n;
      pend_q    <= pend_n;
`endif
    end
  end

  // line levels decoded straight from flops
  always_comb begin
    scl           = 1'b1;
    sda_drive_low = 1'b0;
    unique case (state_q)
      START:  sda_drive_low = 1'b1;
      BIT: begin
        scl           = phase_q;
        sda_drive_low = ~cur_bit;
      end
      ACK:    scl = phase_q;
      STOP_A: begin
        scl           = 1'b0;
        sda_drive_low = 1'b1;
      end
      STOP_B: sda_drive_low = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_channel_streamer.sv
// Bench for i2c_channel_streamer: I2C target model decodes SDA bytes,
// reference model predicts bytes, frame length and err.
module tb_i2c_channel_streamer;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int DIV    = 4;
  localparam int TOTAL  = 1 + NUM_CH * DATA_W / 8;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [6:0]  i2c_address = 0;
  logic        endian = 0;
  logic [31:0] ch_data = 0;
  logic        scl, sda_drive_low, sda_i;
  logic        busy, done, err;

  int checks = 0;
  int passed = 0;

  i2c_channel_streamer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .i2c_address(i2c_address), .endian(endian),
    .ch_data(ch_data), .scl(scl),
    .sda_drive_low(sda_drive_low), .sda_i(sda_i),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // target model
  int         bitpos = 0;
  int         rx_idx = 0;
  int         nack_byte = -1;
  bit         hold_high = 0;
  logic [7:0] sh = 0;
  logic [7:0] rxq[$];
  logic       prev_scl = 1;
  logic       prev_sda = 0;

  assign sda_i = hold_high ? 1'b1 :
                 (bitpos == 8) ? (rx_idx == nack_byte) : 1'b1;

  always @(scl or sda_drive_low) begin
    if (scl && prev_scl && sda_drive_low && !prev_sda) begin
      bitpos = -1;
      rx_idx = 0;
      rxq.delete();
    end else if (scl && !prev_scl) begin
      if (bitpos >= 0 && bitpos < 8)
        sh = {sh[6:0], ~sda_drive_low};
    end else if (!scl && prev_scl) begin
      bitpos++;
      if (bitpos == 9) begin
        rxq.push_back(sh);
        rx_idx++;
        bitpos = 0;
      end
    end
    prev_scl = scl;
    prev_sda = sda_drive_low;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int flen(input int k);
    return DIV * (1 + 18 * (k + 1) + 3);
  endfunction

  task automatic run(input logic [6:0] a, input logic e,
                     input logic [31:0] d, input int nb,
                     input bit mid, input bit b2b);
    logic [7:0] ex[$];
    logic [15:0] w;
    int nbytes, exp_len, cycles;
    bit gap, to;
    ex.delete();
    ex.push_back({a, 1'b0});
    for (int c = 0; c < NUM_CH; c++) begin
      w = d[c*16 +: 16];
      if (e) begin
        ex.push_back(w[15:8]); ex.push_back(w[7:0]);
      end else begin
        ex.push_back(w[7:0]); ex.push_back(w[15:8]);
      end
    end
    nbytes = (nb < 0) ? TOTAL : nb + 1;
    exp_len = flen(nbytes - 1);
`ifdef I2C_NACK_RETRY_EN
    if (nb >= 0) exp_len = 2 * exp_len + DIV;
`endif
    i2c_address = a; endian = e; ch_data = d;
    nack_byte = nb;
    @(negedge clk) start = 1;
    @(posedge clk); #1 start = 0;
    check("start_busy", busy, 1);
    check("start_sda", sda_drive_low, 1);
    check("start_scl", scl, 1);
    check("start_err", err, 0);
    for (int f = 0; f < (b2b ? 2 : 1); f++) begin
      cycles = 0; gap = 0; to = 0;
      while (1) begin
        @(posedge clk); #1;
        cycles++;
        if (done === 1'b1) break;
        if (busy !== 1'b1) gap = 1;
        if (cycles > 5000) begin to = 1; break; end
        if (mid && cycles == 60) begin
          start = 1; ch_data = ~d;
          i2c_address = ~a; endian = ~e;
        end else start = 0;
      end
      check("timeout", to, 0);
      check("busy_gap", gap, 0);
      check("frame_len", cycles, exp_len);
      check("done_busy", busy, 0);
      check("err", err, (nb >= 0));
      check("nbytes", rxq.size(), nbytes);
      for (int i = 0; i < nbytes && i < rxq.size(); i++)
        check($sformatf("byte%0d", i), rxq[i], ex[i]);
      if (f == 0 && b2b) begin
        start = 1;
        @(posedge clk); #1 start = 0;
        check("b2b_busy", busy, 1);
        check("b2b_sda", sda_drive_low, 1);
      end else begin
        @(posedge clk); #1;
        check("done_pulse", done, 0);
      end
    end
  endtask

  initial begin
    int n;
    bit to;
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda_drive_low, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    #20 rst_n = 1;
    repeat (2) @(posedge clk);

    run(7'h29, 1, {16'h5678, 16'h1234}, -1, 0, 0);
    run(7'h29, 0, {16'h5678, 16'h1234}, -1, 0, 0);
    hold_high = 1;
    run(7'h29, 1, {16'h5678, 16'h1234}, 0, 0, 0);
    hold_high = 0;
    run(7'h29, 1, {16'h5678, 16'h1234}, 2, 0, 0);
    run(7'h15, 1, {16'hA5C3, 16'h0F1E}, -1, 1, 0);
    run(7'h7F, 0, {16'hBEEF, 16'hCAFE}, -1, 0, 1);

    // reset mid-frame during data byte 2
    nack_byte = -1;
    i2c_address = 7'h33; endian = 1; ch_data = 32'h11223344;
    @(negedge clk) start = 1;
    @(posedge clk); #1 start = 0;
    n = 0; to = 0;
    while (rx_idx < 2) begin
      @(posedge clk); n++;
      if (n > 2000) begin to = 1; break; end
    end
    check("rst_wait", to, 0);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda_drive_low, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk) rst_n = 1;
    run(7'h33, 1, 32'h11223344, -1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      n = ($urandom_range(0, 2) == 0) ?
          int'($urandom_range(0, TOTAL - 1)) : -1;
      run(7'($urandom), 1'($urandom), $urandom, n, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
